// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer-side byte stream plus serial line and status of the UART transmitter.
interface uart_tx_fifo_if #(parameter int FIFO_DEPTH = 16);
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    logic tx;
    logic busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    modport master (output tx_data, tx_valid, input tx_ready, tx, busy, fifo_count);
    modport slave (input tx_data, tx_valid, output tx_ready, tx, busy, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a circular FIFO, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input logic clk_100,
    input logic rst,
    uart_tx_fifo_if.slave bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW = $clog2(DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic [7:0] shift, shift_n;
    logic tx_r, tx_n;
    logic push, pop, bit_end, has_data;

    assign has_data = count != '0;
    assign bit_end = cnt == CW'(DIV - 1);
    assign push = bus.tx_valid & bus.tx_ready;
    assign bus.tx_ready = count != (AW + 1)'(FIFO_DEPTH);
    assign bus.tx = tx_r;
    assign bus.busy = (state != IDLE) | has_data;
    assign bus.fifo_count = count;

    always_ff @(posedge clk_100)
        if (push) mem[wr_ptr] <= bus.tx_data;

    always_ff @(posedge clk_100 or posedge rst)
        if (rst) begin
            state <= IDLE;
            tx_r <= 1'b1;
            cnt <= '0;
            idx <= '0;
            shift <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            tx_r <= tx_n;
            cnt <= cnt_n;
            idx <= idx_n;
            shift <= shift_n;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end

    // Pops happen only from IDLE or at the end of STOP, so frames chain without a gap.
    always_comb begin
        state_n = state;
        tx_n = tx_r;
        idx_n = idx;
        shift_n = shift;
        pop = 1'b0;
        cnt_n = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
        case (state)
            IDLE: if (has_data) begin
                pop = 1'b1;
                shift_n = mem[rd_ptr];
                state_n = START;
                tx_n = 1'b0;
            end
            START: if (bit_end) begin
                state_n = DATA;
                idx_n = '0;
                tx_n = shift[0];
            end
            DATA: if (bit_end) begin
                idx_n = idx + 3'd1;
`ifdef UART_TX_PARITY_EN
                state_n = (idx == 3'd7) ? PARITY : DATA;
                tx_n = (idx == 3'd7) ? ^shift : shift[3'(idx + 3'd1)];
`else
                state_n = (idx == 3'd7) ? STOP : DATA;
                tx_n = (idx == 3'd7) ? 1'b1 : shift[3'(idx + 3'd1)];
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                state_n = STOP;
                tx_n = 1'b1;
            end
`endif
            STOP: if (bit_end) begin
                pop = has_data;
                shift_n = has_data ? mem[rd_ptr] : shift;
                state_n = has_data ? START : IDLE;
                tx_n = !has_data;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: frame-timeline reference model checked every cycle, plus directed literal line checks.
// Honours UART_TX_PARITY_EN to match the DUT build.
module tb_uart_tx_fifo;
    localparam int DIV = 10;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
    localparam logic [0:FB-1] A5_LINE = 11'b01010010101;
`else
    localparam int FB = 10;
    localparam logic [0:FB-1] A5_LINE = 10'b0101001011;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int passed = 0;
    int total = 0;
    logic [7:0] q[$];
    logic [7:0] rxq[$];
    logic [7:0] cur = 8'h00;
    logic [7:0] rx_b;
    bit act = 1'b0;
    bit pushed;
    int t = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
        .clk_100(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (FB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Model: a frame is a timeline of FB bits of DIV cycles; the queue holds bytes not yet started.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            act = 1'b0;
            t = 0;
        end else begin
            pushed = bus.tx_valid && q.size() < DEPTH;
            if (act) begin
                t++;
                if (t == FB * DIV) begin
                    if (q.size() != 0) begin
                        cur = q.pop_front();
                        t = 0;
                    end else act = 1'b0;
                end
            end else if (q.size() != 0) begin
                cur = q.pop_front();
                act = 1'b1;
                t = 0;
            end
            if (pushed) q.push_back(bus.tx_data);
        end
    end

    initial forever begin
        @(negedge clk);
        chk("model_tx", bus.tx, act ? exp_bit(cur, t / DIV) : 1'b1);
        chk("model_count", bus.fifo_count, q.size());
        chk("model_busy", bus.busy, act || q.size() != 0);
        chk("model_ready", bus.tx_ready, q.size() != DEPTH);
    end

    // Line decoder sampling mid-bit, used to confirm byte order end to end.
    initial forever begin
        @(negedge clk);
        if (!rst && bus.tx === 1'b0) begin
            repeat (DIV / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (DIV) @(negedge clk);
                rx_b[k] = bus.tx;
            end
            repeat (DIV * (FB - 9)) @(negedge clk);
            rxq.push_back(rx_b);
        end
    end

    task automatic wait_to(input int e);
        int g = 0;
        while (cyc < e && g < 100000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic push_one(input logic [7:0] b, output int n);
        @(negedge clk);
        bus.tx_data = b;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        n = cyc;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("idle_reached", bus.busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n, m;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_tx", bus.tx, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_ready", bus.tx_ready, 1'b1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        push_one(8'hA5, n);
        chk("a5_idle_at_push", bus.tx, 1'b1);
        wait_to(n + 1);
        chk("a5_fall", bus.tx, 1'b0);
        for (int k = 1; k < FB; k++) begin
            wait_to(n + 1 + DIV * k);
            chk($sformatf("a5_bit%0d", k), bus.tx, A5_LINE[k]);
        end
        wait_to(n + FB * DIV);
        chk("a5_busy_hold", bus.busy, 1'b1);
        wait_to(n + 1 + FB * DIV);
        chk("a5_busy_fall", bus.busy, 1'b0);
        chk("a5_tx_idle", bus.tx, 1'b1);

        @(negedge clk);
        bus.tx_data = 8'h00;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        m = cyc;
        bus.tx_data = 8'hFF;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("b2b_count1", bus.fifo_count, 1);
        chk("b2b_start1", bus.tx, 1'b0);
        wait_to(m + FB * DIV);
        chk("b2b_stop1", bus.tx, 1'b1);
        chk("b2b_count_pre", bus.fifo_count, 1);
        wait_to(m + 1 + FB * DIV);
        chk("b2b_start2", bus.tx, 1'b0);
        chk("b2b_count0", bus.fifo_count, 0);
        wait_idle();

        rxq.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                chk("full_count", bus.fifo_count, DEPTH);
                chk("full_ready", bus.tx_ready, 1'b0);
            end
            bus.tx_data = 8'(17 * (i + 1));
            bus.tx_valid = 1'b1;
        end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("full_ignored", bus.fifo_count, DEPTH);
        wait_idle();
        chk("full_rx_len", rxq.size(), 5);
        for (int i = 0; i < 5; i++) chk($sformatf("full_rx%0d", i), rxq[i], 8'(17 * (i + 1)));

        rxq.delete();
        @(negedge clk);
        bus.tx_data = 8'hC1;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        n = cyc;
        bus.tx_data = 8'hC2;
        @(negedge clk);
        bus.tx_data = 8'hC3;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_to(n + FB * DIV);
        chk("sim_count_pre", bus.fifo_count, 2);
        bus.tx_data = 8'hC4;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("sim_count_post", bus.fifo_count, 2);
        chk("sim_start", bus.tx, 1'b0);
        wait_idle();
        chk("sim_rx_len", rxq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("sim_rx%0d", i), rxq[i], 8'hC1 + 8'(i));

        push_one(8'h3C, n);
        @(negedge clk);
        bus.tx_data = 8'h5A;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data = 8'hA6;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_to(n + 1 + DIV * 4 + DIV / 2);
        chk("mid_count", bus.fifo_count, 2);
        chk("mid_bit3", bus.tx, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_tx", bus.tx, 1'b1);
        chk("arst_count", bus.fifo_count, 0);
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_ready", bus.tx_ready, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (FB * DIV * 3) @(negedge clk);
        chk("post_rst_busy", bus.busy, 1'b0);
        chk("post_rst_tx", bus.tx, 1'b1);

`ifdef UART_TX_PARITY_EN
        push_one(8'h07, n);
        for (int k = 0; k < FB; k++) begin
            logic [0:10] p07;
            p07 = 11'b01110000011;
            wait_to(n + 1 + DIV * k);
            chk($sformatf("par_bit%0d", k), bus.tx, p07[k]);
        end
        wait_to(n + FB * DIV);
        chk("par_busy_hold", bus.busy, 1'b1);
        wait_to(n + 1 + FB * DIV);
        chk("par_busy_fall", bus.busy, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter with a small input FIFO; the outbound counterpart of the CPU's serial program-load receiver.
- Serializes bytes from the CPU/MMIO side onto the `tx` pin as 8N1 frames, LSB first.
- Sits in `cpu_top` next to the receiver and drives the board `tx` output.
- Used for debug/print output and for echoing received program bytes.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 115200, line rate; bit period DIV = CLK_FREQ / BAUD (integer floor, must be >= 2).
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clk_100  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- tx_data  input  8  byte to enqueue.
- tx_valid  input  1  producer asserts when tx_data is valid.
- tx_ready  output  1  FIFO can accept; a byte is accepted on a rising edge with tx_valid & tx_ready.
- tx  output  1  serial line, idle high, registered.
- busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, not counting the byte in flight.

Behaviour:
- Reset (async, any time, including mid-frame):
  - tx=1, state=IDLE, FIFO emptied, fifo_count=0, busy=0, tx_ready=1, baud counter=0, bit index=0.
  - A partial frame is abandoned; the line returns high immediately.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - tx_ready = (fifo_count != FIFO_DEPTH), registered-count based, no combinational path from tx_valid.
  - Push when full is impossible (ready low); tx_valid is ignored.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pop only happens from IDLE, or at the end of STOP.
- Baud timing:
  - Counter runs 0..DIV-1 in every non-IDLE state.
  - A bit ends on the edge where the counter equals DIV-1; the counter then resets to 0.
  - Each bit is held exactly DIV cycles.
- State machine (IDLE, START, DATA, STOP; PARITY only with the optional feature):
  - IDLE: tx=1. If fifo_count != 0, on the next edge pop the head into the shift register and go to START with tx=0 (registered).
    - A byte accepted into an empty FIFO while IDLE at edge N gives tx falling at edge N+1.
  - START: hold tx=0 for DIV cycles, then go to DATA with bit index 0 and tx=shift[0].
  - DATA: shift LSB first. After bit 7's DIV cycles, go to STOP (or PARITY) with tx=1.
  - STOP: hold tx=1 for DIV cycles. At its end:
    - FIFO non-empty: pop and go straight to START. Back-to-back frames have no idle gap; frame period is exactly 10*DIV cycles.
    - FIFO empty: go to IDLE.
- busy = (state != IDLE) | (fifo_count != 0), combinational from registers.
- Pushes during transmission never disturb the byte in flight.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Transmits the even-parity bit (XOR of the 8 data bits) for DIV cycles.
  - Frame is 11*DIV cycles.
- Undefined:
  - No PARITY state, no parity logic; 8N1, 10*DIV cycles.

Test Plan:
- Setup for all scenarios: CLK_FREQ=1000, BAUD=100 (DIV=10), FIFO_DEPTH=4.
- Single byte: push 0xA5 while idle at edge N.
  - tx falls at N+1.
  - Line sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles.
  - busy falls 100 cycles after N+1; tx stays 1.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles.
  - Second start bit begins exactly 100 cycles after the first.
  - No idle cycle between frames.
  - fifo_count goes 1 then 0 at the second pop.
- FIFO full: push 5 bytes while the first frame is running.
  - First byte pops immediately; the next 4 fill the FIFO and tx_ready=0 with fifo_count=4.
  - A 6th tx_valid is ignored.
  - All 5 bytes are sent in order with no duplicates.
- Simultaneous push/pop: push on the same edge as the end-of-STOP pop with fifo_count=2.
  - fifo_count stays 2.
  - Byte order preserved.
- Reset mid-frame: assert rst during DATA bit 3 of 0x3C, with 2 bytes queued.
  - tx=1 and fifo_count=0 asynchronously.
  - After release, no further frames are sent until a new push.
- Parity (UART_TX_PARITY_EN defined): send 0x07.
  - Parity bit = 1; frame 0,1,1,1,0,0,0,0,0,1,1.
  - Frame lasts 110 cycles.
